// File: rtl/ppu_pkg.sv
// Shared definitions for the vblank-gated PPU write queue.
//   PPU_ADDR_W / PPU_DATA_W : widths of the PPU register bus
//   ACK_ADDR_DEFAULT        : CPU address whose write clears the frame interrupt
//   wq_entry_t              : one queued register write {addr, data}
//   drain_state_e           : drain FSM states
package ppu_pkg;

  localparam int unsigned PPU_ADDR_W = 12;
  localparam int unsigned PPU_DATA_W = 32;

  localparam logic [PPU_ADDR_W-1:0] ACK_ADDR_DEFAULT = 12'hFFF;

  typedef struct packed {
    logic [PPU_ADDR_W-1:0] addr;
    logic [PPU_DATA_W-1:0] data;
  } wq_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StHold
  } drain_state_e;

endpackage

// File: rtl/vblank_write_queue_if.sv
// CPU-side and PPU-side bus bundle for vblank_write_queue.
//   CPU side : chipselect, write, address, write_data (to queue); waitrequest, irq (from queue)
//   PPU side : ppu_chipselect, ppu_write, ppu_address, ppu_write_data (from queue)
// Modports: master = CPU / bench view, slave = queue view.
interface vblank_write_queue_if;
  import ppu_pkg::*;

  logic                  chipselect;
  logic                  write;
  logic [PPU_ADDR_W-1:0] address;
  logic [PPU_DATA_W-1:0] write_data;
  logic                  waitrequest;
  logic                  irq;

  logic                  ppu_chipselect;
  logic                  ppu_write;
  logic [PPU_ADDR_W-1:0] ppu_address;
  logic [PPU_DATA_W-1:0] ppu_write_data;

  modport master (
    output chipselect, write, address, write_data,
    input  waitrequest, irq, ppu_chipselect, ppu_write, ppu_address, ppu_write_data
  );

  modport slave (
    input  chipselect, write, address, write_data,
    output waitrequest, irq, ppu_chipselect, ppu_write, ppu_address, ppu_write_data
  );

endinterface

// File: rtl/wq_fifo.sv
// Synchronous FIFO holding queued PPU register writes.
//   clk, reset   : clock, asynchronous active-low reset (pointers and count cleared)
//   push_i       : write push_data_i at the tail (ignored when full)
//   pop_i        : advance the head (ignored when empty)
//   pop_data_o   : current head entry, valid when !empty_o
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
//   count_o      : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module wq_fifo
  import ppu_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  wq_entry_t              push_data_i,
  input  logic                   pop_i,
  output wq_entry_t              pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wq_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/vblank_write_queue.sv
// Queues CPU writes to PPU registers and replays them toward ppu_top while the gate is open,
// so register updates land during vertical blank. Also raises a per-frame interrupt.
//   clk, reset  : single clock, asynchronous active-low reset
//   vblank      : vertical-blank level from the VGA timing stage
//   bus (slave) : CPU bus in (chipselect/write/address/write_data), waitrequest, irq,
//                 registered PPU write bus out (ppu_chipselect/ppu_write/ppu_address/ppu_write_data)
//   level       : current number of queued entries
// Parameters: DEPTH (power of two, 4..64), ACK_ADDR (writes here clear irq, never queued).
// Macro VBLANK_GATE_EN: defined -> gate is vblank; undefined -> gate is always open, the queue
// drains whenever non-empty and StHold is never entered. irq behaves the same either way.
module vblank_write_queue
  import ppu_pkg::*;
#(
  parameter int unsigned           DEPTH    = 16,
  parameter logic [PPU_ADDR_W-1:0] ACK_ADDR = ACK_ADDR_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vblank,
  vblank_write_queue_if.slave    bus,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  drain_state_e          state_q, state_d;
  logic                  gate;
  logic                  cpu_wr, is_ack, data_wr;
  logic                  push, pop, full, empty;
  wq_entry_t             push_entry, head_entry;
  logic [CntW-1:0]       count, count_after;
  logic                  vblank_q;
  logic                  irq_q, irq_d;
  logic                  ppu_wr_q, ppu_wr_d;
  logic [PPU_ADDR_W-1:0] ppu_addr_q, ppu_addr_d;
  logic [PPU_DATA_W-1:0] ppu_data_q, ppu_data_d;

`ifdef VBLANK_GATE_EN
  assign gate = vblank;
`else
  assign gate = 1'b1;
`endif

  // CPU side: ACK writes never touch the queue and never stall.
  assign cpu_wr  = bus.chipselect & bus.write;
  assign is_ack  = (bus.address == ACK_ADDR);
  assign data_wr = cpu_wr & ~is_ack;
  assign push    = data_wr & ~full;

  assign push_entry.addr = bus.address;
  assign push_entry.data = bus.write_data;

  // A pop in StDrain always completes even if the gate closes this cycle; the FSM only stops
  // further pops once it has sampled the closed gate.
  assign pop = (state_q == StDrain) & ~empty;

  assign count_after = count + CntW'(push) - CntW'(pop);

  wq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .pop_data_o  (head_entry),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (count)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StHold: begin
        if (gate && !empty) state_d = StDrain;
      end
      StDrain: begin
        if (count_after == '0) begin
          state_d = StIdle;
        end else if (!gate) begin
          state_d = StHold;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ppu_wr_d   = pop;
    ppu_addr_d = '0;
    ppu_data_d = '0;
    if (pop) begin
      ppu_addr_d = head_entry.addr;
      ppu_data_d = head_entry.data;
    end
  end

  // A vblank rising edge wins over a coincident ACK.
  assign irq_d = (vblank & ~vblank_q) | (irq_q & ~(cpu_wr & is_ack));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      vblank_q   <= 1'b0;
      irq_q      <= 1'b0;
      ppu_wr_q   <= 1'b0;
      ppu_addr_q <= '0;
      ppu_data_q <= '0;
    end else begin
      state_q    <= state_d;
      vblank_q   <= vblank;
      irq_q      <= irq_d;
      ppu_wr_q   <= ppu_wr_d;
      ppu_addr_q <= ppu_addr_d;
      ppu_data_q <= ppu_data_d;
    end
  end

  assign bus.waitrequest    = data_wr & full;
  assign bus.irq            = irq_q;
  assign bus.ppu_chipselect = ppu_wr_q;
  assign bus.ppu_write      = ppu_wr_q;
  assign bus.ppu_address    = ppu_addr_q;
  assign bus.ppu_write_data = ppu_data_q;
  assign level              = count;

endmodule

// File: tb/tb_vblank_write_queue.sv
// Bench for vblank_write_queue: a queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations. Scenarios follow the VBLANK_GATE_EN build.
module tb_vblank_write_queue;
  import ppu_pkg::*;

  localparam int unsigned           DEPTH = 16;
  localparam logic [PPU_ADDR_W-1:0] ACK   = 12'hFFF;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  vblank;
  logic [$clog2(DEPTH):0] level;

  vblank_write_queue_if bus ();

  vblank_write_queue #(
    .DEPTH    (DEPTH),
    .ACK_ADDR (ACK)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .vblank (vblank),
    .bus    (bus),
    .level  (level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  wq_entry_t             mq[$];
  bit                    m_drain, m_vbq, m_irq, m_pcs;
  logic [PPU_ADDR_W-1:0] m_pa;
  logic [PPU_DATA_W-1:0] m_pd;
  int                    m_before;
  bit                    m_push, m_pop, m_ack, m_gate;
  wq_entry_t             m_head;
  wq_entry_t             outs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model update on the active edge, comparison 1 time unit later.
  always @(posedge clk) begin
    if (!reset) begin
      mq.delete();
      m_drain = 1'b0;
      m_vbq   = 1'b0;
      m_irq   = 1'b0;
      m_pcs   = 1'b0;
      m_pa    = '0;
      m_pd    = '0;
    end else begin
      m_before = mq.size();
      m_ack    = bus.chipselect && bus.write && (bus.address == ACK);
      m_push   = bus.chipselect && bus.write && (bus.address != ACK) && (m_before != DEPTH);
      m_pop    = m_drain && (m_before != 0);
`ifdef VBLANK_GATE_EN
      m_gate = vblank;
`else
      m_gate = 1'b1;
`endif
      m_pcs = m_pop;
      m_pa  = '0;
      m_pd  = '0;
      if (m_pop) begin
        m_head = mq.pop_front();
        m_pa   = m_head.addr;
        m_pd   = m_head.data;
      end
      if (m_push) mq.push_back(wq_entry_t'{addr: bus.address, data: bus.write_data});
      m_drain = m_gate && (m_drain ? (mq.size() != 0) : (m_before != 0));
      if (vblank && !m_vbq) m_irq = 1'b1;
      else if (m_ack) m_irq = 1'b0;
      m_vbq = vblank;
    end
    #1;
    chk("waitrequest", bus.waitrequest,
        bus.chipselect && bus.write && (bus.address != ACK) && (mq.size() == DEPTH));
    chk("ppu_chipselect", bus.ppu_chipselect, m_pcs);
    chk("ppu_write", bus.ppu_write, m_pcs);
    chk("ppu_address", bus.ppu_address, m_pa);
    chk("ppu_write_data", bus.ppu_write_data, m_pd);
    chk("irq", bus.irq, m_irq);
    chk("level", level, mq.size());
    if (reset && bus.ppu_write)
      outs.push_back(wq_entry_t'{addr: bus.ppu_address, data: bus.ppu_write_data});
  end

  // Called at a falling edge; returns at the falling edge after the accepting rising edge,
  // leaving the bus driven so writes can be issued back to back.
  task automatic cpu_write(input logic [11:0] a, input logic [31:0] d);
    int waited;
    waited = 0;
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = a;
    bus.write_data = d;
    #1;
    while (bus.waitrequest && waited < 300) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (bus.waitrequest) begin
      tests++;
      fails++;
      $display("FAIL cpu_write_timeout: waitrequest still 1 after %0d cycles, addr %0h", waited, a);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.address    = '0;
    bus.write_data = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_outs(input string nm, input int n, input logic [11:0] a0,
                          input logic [31:0] d0);
    chk({nm, "_count"}, outs.size(), n);
    for (int i = 0; i < outs.size() && i < n; i++) begin
      chk({nm, "_addr"}, outs[i].addr, a0 + 12'(i));
      chk({nm, "_data"}, outs[i].data, d0 + 32'(i));
    end
  endtask

  task automatic chk_reset_zero(input string nm);
    chk({nm, "_waitrequest"}, bus.waitrequest, 0);
    chk({nm, "_irq"}, bus.irq, 0);
    chk({nm, "_level"}, level, 0);
    chk({nm, "_ppu_cs"}, bus.ppu_chipselect, 0);
    chk({nm, "_ppu_wr"}, bus.ppu_write, 0);
    chk({nm, "_ppu_addr"}, bus.ppu_address, 0);
    chk({nm, "_ppu_data"}, bus.ppu_write_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.address    = '0;
    bus.write_data = '0;
    reset          = 1'b0;
`ifdef VBLANK_GATE_EN
    vblank = 1'b1;
`else
    vblank = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk_reset_zero("reset");
    reset = 1'b1;
    idle(2);

    // Push-to-output latency: push edge P1, nothing at P2, output at P3.
    cpu_write(12'h123, 32'hDEAD_BEEF);
    idle(0);
    @(posedge clk); #1;
    chk("lat_p2_write", bus.ppu_write, 0);
    @(posedge clk); #1;
    chk("lat_p3_write", bus.ppu_write, 1);
    chk("lat_p3_addr", bus.ppu_address, 12'h123);
    chk("lat_p3_data", bus.ppu_write_data, 32'hDEAD_BEEF);
    @(negedge clk);
    idle(3);

`ifdef VBLANK_GATE_EN
    // Writes held while vblank is low, then drained in order.
    vblank = 1'b0;
    idle(2);
    outs.delete();
    for (int i = 0; i < 3; i++) cpu_write(12'h010 + 12'(i), 32'hA + 32'(i));
    idle(3);
    chk("hold3_level", level, 3);
    chk("hold3_no_out", outs.size(), 0);
    vblank = 1'b1;
    idle(8);
    chk_outs("drain3", 3, 12'h010, 32'hA);
    chk("drain3_level", level, 0);

    // Overfill: the 17th write stalls until the first pop frees a slot.
    vblank = 1'b0;
    idle(2);
    outs.delete();
    for (int i = 0; i < 16; i++) cpu_write(12'h100 + 12'(i), 32'h1000 + 32'(i));
    fork
      cpu_write(12'h110, 32'h1010);
      begin
        @(negedge clk); #2;
        chk("full_waitrequest", bus.waitrequest, 1);
        chk("full_level", level, 16);
        repeat (2) @(negedge clk);
        vblank = 1'b1;
      end
    join
    idle(25);
    chk_outs("drain17", 17, 12'h100, 32'h1000);
    chk("drain17_level", level, 0);

    // Gate closes after three pops; the rest wait for the next blank.
    vblank = 1'b0;
    idle(2);
    outs.delete();
    for (int i = 0; i < 8; i++) cpu_write(12'h200 + 12'(i), 32'h2000 + 32'(i));
    idle(0);
    vblank = 1'b1;
    repeat (3) @(negedge clk);
    vblank = 1'b0;
    idle(5);
    chk_outs("partial3", 3, 12'h200, 32'h2000);
    chk("partial3_level", level, 5);
    vblank = 1'b1;
    idle(12);
    chk_outs("partial8", 8, 12'h200, 32'h2000);
    chk("partial8_level", level, 0);
`else
    // Ungated: back-to-back writes stream straight through in order.
    outs.delete();
    for (int i = 0; i < 5; i++) cpu_write(12'h040 + 12'(i), 32'h400 + 32'(i));
    idle(8);
    chk_outs("stream5", 5, 12'h040, 32'h400);
    chk("stream5_level", level, 0);
`endif

    // Interrupt set/clear and ACK-vs-edge priority.
    vblank = 1'b0;
    idle(2);
    cpu_write(ACK, 32'h0);
    idle(0);
    chk("irq_clear0", bus.irq, 0);
    vblank = 1'b1;
    @(posedge clk); #1;
    chk("irq_rise", bus.irq, 1);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write      = 1'b0;
    bus.address    = 12'h050;
    bus.write_data = 32'h5;
    repeat (3) @(negedge clk);
    chk("read_ignored_level", level, 0);
    cpu_write(ACK, 32'h0);
    idle(0);
    chk("irq_ack", bus.irq, 0);
    chk("ack_level", level, 0);
    vblank = 1'b0;
    idle(2);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = ACK;
    vblank         = 1'b1;
    @(negedge clk);
    idle(0);
    chk("irq_coincident", bus.irq, 1);
    idle(2);

    // Reset in the middle of a drain discards everything.
`ifdef VBLANK_GATE_EN
    vblank = 1'b0;
    idle(2);
    for (int i = 0; i < 8; i++) cpu_write(12'h300 + 12'(i), 32'h3000 + 32'(i));
    idle(0);
    vblank = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_level", level, 6);
`else
    for (int i = 0; i < 3; i++) cpu_write(12'h300 + 12'(i), 32'h3000 + 32'(i));
    idle(0);
    waited = 0;
    while (!bus.ppu_write && waited < 10) begin
      @(negedge clk);
      waited++;
    end
`endif
    chk("mid_ppu_active", bus.ppu_write, 1);
    #2 reset = 1'b0;
    #1;
    chk_reset_zero("mid_reset");
    repeat (2) @(negedge clk);
    outs.delete();
    reset = 1'b1;
    idle(10);
    chk("post_reset_outs", outs.size(), 0);
    chk("post_reset_level", level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
